// File: rtl/universal_register_pkg.sv
// Shared definitions for the universal register.
// Contents:
//   MODE_W - width of the operation select field
//   mode_t - encoding of the eight register operations
package universal_register_pkg;

    localparam int MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_SHR  = 3'b011,
        MODE_ROL  = 3'b100,
        MODE_ROR  = 3'b101,
        MODE_INC  = 3'b110,
        MODE_DEC  = 3'b111
    } mode_t;

endpackage

// File: rtl/universal_register_if.sv
// Bus interface of the universal register.
// Signals:
//   en, mode, D, sin_l, sin_r - control and data driven by the master
//   Q, co, zero               - register contents and flags driven by the slave
// Modports: master (user of the register), slave (the register itself).
interface universal_register_if
    import universal_register_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic              en;
    logic [MODE_W-1:0] mode;
    logic [WIDTH-1:0]  D;
    logic              sin_l;
    logic              sin_r;
    logic [WIDTH-1:0]  Q;
    logic              co;
    logic              zero;

    modport master (
        output en, mode, D, sin_l, sin_r,
        input  Q, co, zero
    );

    modport slave (
        input  en, mode, D, sin_l, sin_r,
        output Q, co, zero
    );

endinterface

// File: rtl/universal_register_next.sv
// Next-state logic of the universal register (purely combinational).
// Ports:
//   q, co       - current register contents and flag
//   mode        - operation select
//   d           - parallel load data
//   sin_l/sin_r - serial inputs for shift-right / shift-left
//   q_next      - contents after the operation
//   co_next     - flag after the operation
module universal_register_next
    import universal_register_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]  q,
    input  logic              co,
    input  logic [MODE_W-1:0] mode,
    input  logic [WIDTH-1:0]  d,
    input  logic              sin_l,
    input  logic              sin_r,
    output logic [WIDTH-1:0]  q_next,
    output logic              co_next
);

    // Operation decode; unselected inputs never reach the result.
    always_comb begin
        q_next  = q;
        co_next = co;
        case (mode)
            MODE_HOLD: begin
                q_next  = q;
                co_next = co;
            end
            MODE_LOAD: begin
                q_next  = d;
                co_next = 1'b0;
            end
            MODE_SHL: begin
                q_next  = {q[WIDTH-2:0], sin_r};
                co_next = q[WIDTH-1];
            end
            MODE_SHR: begin
                q_next  = {sin_l, q[WIDTH-1:1]};
                co_next = q[0];
            end
            MODE_ROL: begin
                q_next  = {q[WIDTH-2:0], q[WIDTH-1]};
                co_next = q[WIDTH-1];
            end
            MODE_ROR: begin
                q_next  = {q[0], q[WIDTH-1:1]};
                co_next = q[0];
            end
            // Extra top bit captures the carry out of all-ones.
            MODE_INC: {co_next, q_next} = {1'b0, q} + {{WIDTH{1'b0}}, 1'b1};
            // Extra top bit becomes 1 only when subtracting from zero (borrow).
            MODE_DEC: {co_next, q_next} = {1'b0, q} - {{WIDTH{1'b0}}, 1'b1};
            default: begin
                q_next  = q;
                co_next = co;
            end
        endcase
    end

endmodule

// File: rtl/universal_register.sv
// Parametrised datapath register: hold, load, shifts, rotates, inc/dec.
// Ports:
//   clk - system clock, rising edge
//   clr - synchronous active-low clear (loads RESET_VAL, clears co)
//   bus - slave side of universal_register_if (en, mode, D, sin_l, sin_r,
//         Q, co, zero)
// Q and co are registered; zero is decoded from Q in the same cycle.
module universal_register
    import universal_register_pkg::*;
#(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  clr,
    universal_register_if.slave   bus
);

    logic [WIDTH-1:0] q_r;
    logic             co_r;
    logic [WIDTH-1:0] q_next;
    logic             co_next;

    universal_register_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .q       (q_r),
        .co      (co_r),
        .mode    (bus.mode),
        .d       (bus.D),
        .sin_l   (bus.sin_l),
        .sin_r   (bus.sin_r),
        .q_next  (q_next),
        .co_next (co_next)
    );

    // State flops: clear beats enable, enable beats mode.
    always_ff @(posedge clk) begin
        if (!clr) begin
            q_r  <= RESET_VAL;
            co_r <= 1'b0;
        end else if (bus.en) begin
            q_r  <= q_next;
            co_r <= co_next;
        end else begin
            q_r  <= q_r;
            co_r <= co_r;
        end
    end

    assign bus.Q    = q_r;
    assign bus.co   = co_r;
    assign bus.zero = ~|q_r;

endmodule

// File: tb/tb_universal_register.sv
// Self-checking bench: three register instances (8-bit reset 0, 8-bit reset
// 5A, 16-bit reset 1234) share stimulus and are compared every cycle against
// an arithmetic reference model, plus hand-computed expectations.
module tb_universal_register;

    localparam int          WID [3] = '{8, 8, 16};
    localparam logic [63:0] RVS [3] = '{64'h0, 64'h5A, 64'h1234};

    logic        clk;
    logic        clr;
    logic [15:0] d_r;

    universal_register_if #(.WIDTH(8))  ifa ();
    universal_register_if #(.WIDTH(8))  ifb ();
    universal_register_if #(.WIDTH(16)) ifc ();

    universal_register #(.WIDTH(8),  .RESET_VAL(8'h00))    u0 (.clk(clk), .clr(clr), .bus(ifa));
    universal_register #(.WIDTH(8),  .RESET_VAL(8'h5A))    u1 (.clk(clk), .clr(clr), .bus(ifb));
    universal_register #(.WIDTH(16), .RESET_VAL(16'h1234)) u2 (.clk(clk), .clr(clr), .bus(ifc));

    logic [63:0] dq  [3];
    logic        dco [3];
    logic        dz  [3];
    assign dq[0] = 64'(ifa.Q);  assign dco[0] = ifa.co; assign dz[0] = ifa.zero;
    assign dq[1] = 64'(ifb.Q);  assign dco[1] = ifb.co; assign dz[1] = ifb.zero;
    assign dq[2] = 64'(ifc.Q);  assign dco[2] = ifc.co; assign dz[2] = ifc.zero;

    int total = 0;
    int bad   = 0;
    logic armed = 1'b0;

    // Literal expectations, one slot per instance.
    logic        lit_on  [3];
    logic [63:0] lit_q   [3];
    logic        lit_co  [3];
    string       lit_name;

    // Reference model state.
    logic [63:0] m_q  [3];
    logic        m_co [3];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Result of one enabled operation as {co, q} from the operation's definition.
    function automatic logic [64:0] ref_step(input logic [63:0] q, input logic c,
                                             input logic [2:0] m, input logic [63:0] d,
                                             input logic sl, input logic sr, input int w);
        logic [63:0] mask;
        logic        msb;
        logic        lsb;
        mask = (64'd1 << w) - 64'd1;
        msb  = q[w-1];
        lsb  = q[0];
        case (m)
            3'd0:    return {c, q};
            3'd1:    return {1'b0, d & mask};
            3'd2:    return {msb, ((q << 1) | 64'(sr)) & mask};
            3'd3:    return {lsb, (q >> 1) | (64'(sl) << (w - 1))};
            3'd4:    return {msb, ((q << 1) | 64'(msb)) & mask};
            3'd5:    return {lsb, (q >> 1) | (64'(lsb) << (w - 1))};
            3'd6:    return {q == mask, (q + 64'd1) & mask};
            default: return {q == 64'd0, (q - 64'd1) & mask};
        endcase
    endfunction

    // Model advance on each rising edge.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            logic [64:0] r;
            r = ref_step(m_q[i], m_co[i], ifa.mode, 64'(d_r), ifa.sin_l, ifa.sin_r, WID[i]);
            if (!clr) begin
                m_q[i]  <= RVS[i];
                m_co[i] <= 1'b0;
            end else if (ifa.en) begin
                m_q[i]  <= r[63:0];
                m_co[i] <= r[64];
            end
        end
    end

    task automatic check(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    // Single compare process: model every cycle, literals when posted.
    always @(negedge clk) begin
        if (armed) begin
            for (int i = 0; i < 3; i++) begin
                check("model_q",    i, dq[i],         m_q[i]);
                check("model_co",   i, 64'(dco[i]),   64'(m_co[i]));
                check("model_zero", i, 64'(dz[i]),    64'(m_q[i] == 64'd0));
                if (lit_on[i]) begin
                    check({lit_name, "_q"},    i, dq[i],       lit_q[i]);
                    check({lit_name, "_co"},   i, 64'(dco[i]), 64'(lit_co[i]));
                    check({lit_name, "_zero"}, i, 64'(dz[i]),  64'(lit_q[i] == 64'd0));
                end
            end
        end
    end

    task automatic op(input logic c, input logic e, input logic [2:0] m,
                      input logic [15:0] d, input logic sl, input logic sr);
        clr = c;
        d_r = d;
        ifa.en = e; ifb.en = e; ifc.en = e;
        ifa.mode = m; ifb.mode = m; ifc.mode = m;
        ifa.D = d[7:0]; ifb.D = d[7:0]; ifc.D = d;
        ifa.sin_l = sl; ifb.sin_l = sl; ifc.sin_l = sl;
        ifa.sin_r = sr; ifb.sin_r = sr; ifc.sin_r = sr;
        @(posedge clk);
        #1;
    endtask

    task automatic post(input int idx, input logic [63:0] q, input logic c);
        lit_on[idx] = 1'b1;
        lit_q[idx]  = q;
        lit_co[idx] = c;
    endtask

    task automatic commit(input string nm);
        lit_name = nm;
        @(negedge clk);
        #1;
        for (int i = 0; i < 3; i++) lit_on[i] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) lit_on[i] = 1'b0;
        lit_name = "";
        clr = 1'b0;
        d_r = 16'h0;
        ifa.en = 1'b0; ifb.en = 1'b0; ifc.en = 1'b0;
        ifa.mode = 3'd0; ifb.mode = 3'd0; ifc.mode = 3'd0;
        ifa.D = 8'h0; ifb.D = 8'h0; ifc.D = 16'h0;
        ifa.sin_l = 1'b0; ifb.sin_l = 1'b0; ifc.sin_l = 1'b0;
        ifa.sin_r = 1'b0; ifb.sin_r = 1'b0; ifc.sin_r = 1'b0;

        // Reset overrides enable and mode.
        op(1'b0, 1'b1, 3'd1, 16'h00FF, 1'b0, 1'b0);
        armed = 1'b1;
        post(0, 64'h00, 1'b0); post(1, 64'h5A, 1'b0); post(2, 64'h1234, 1'b0);
        commit("reset");
        op(1'b0, 1'b0, 3'd1, 16'h00FF, 1'b0, 1'b0);
        post(0, 64'h00, 1'b0); post(1, 64'h5A, 1'b0);
        commit("reset_en0");

        // Load and shifts.
        op(1'b1, 1'b1, 3'd1, 16'h00FF, 1'b0, 1'b0);
        op(1'b1, 1'b1, 3'd2, 16'h0000, 1'b0, 1'b0);
        post(0, 64'hFE, 1'b1); commit("shl");
        op(1'b1, 1'b1, 3'd1, 16'h00AA, 1'b0, 1'b0);
        op(1'b1, 1'b1, 3'd3, 16'h0000, 1'b1, 1'b0);
        post(0, 64'hD5, 1'b0); commit("shr");
        op(1'b1, 1'b1, 3'd1, 16'h0000, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) op(1'b1, 1'b1, 3'd2, 16'h0000, 1'b0, 1'b1);
        post(0, 64'hFF, 1'b0); commit("shl_fill");

        // Rotates.
        op(1'b1, 1'b1, 3'd1, 16'h0081, 1'b0, 1'b0);
        op(1'b1, 1'b1, 3'd4, 16'h0000, 1'b0, 1'b0);
        post(0, 64'h03, 1'b1); commit("rol");
        op(1'b1, 1'b1, 3'd1, 16'h0081, 1'b0, 1'b0);
        op(1'b1, 1'b1, 3'd5, 16'h0000, 1'b0, 1'b0);
        post(0, 64'hC0, 1'b1); commit("ror");
        op(1'b1, 1'b1, 3'd1, 16'h0081, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) op(1'b1, 1'b1, 3'd4, 16'h0000, 1'b0, 1'b0);
        post(0, 64'h81, 1'b1); commit("rol8");

        // Count wrap both ways.
        op(1'b1, 1'b1, 3'd1, 16'h00FE, 1'b0, 1'b0);
        op(1'b1, 1'b1, 3'd6, 16'h0000, 1'b0, 1'b0);
        post(0, 64'hFF, 1'b0); commit("inc1");
        op(1'b1, 1'b1, 3'd6, 16'h0000, 1'b0, 1'b0);
        post(0, 64'h00, 1'b1); commit("inc_wrap");
        op(1'b1, 1'b1, 3'd7, 16'h0000, 1'b0, 1'b0);
        post(0, 64'hFF, 1'b1); commit("dec_wrap");
        op(1'b1, 1'b1, 3'd7, 16'h0000, 1'b0, 1'b0);
        post(0, 64'hFE, 1'b0); commit("dec2");

        // Enable low holds even with LOAD selected; HOLD holds too.
        op(1'b1, 1'b1, 3'd1, 16'h003C, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) op(1'b1, 1'b0, 3'd1, 16'h0055, 1'b1, 1'b1);
        post(0, 64'h3C, 1'b0); commit("en_hold");
        op(1'b1, 1'b1, 3'd0, 16'h0055, 1'b1, 1'b1);
        post(0, 64'h3C, 1'b0); commit("mode_hold");

        // 16-bit wrap and reset during a counting run.
        op(1'b1, 1'b1, 3'd1, 16'hFFFF, 1'b0, 1'b0);
        op(1'b1, 1'b1, 3'd6, 16'h0000, 1'b0, 1'b0);
        post(0, 64'h00, 1'b1); post(2, 64'h0000, 1'b1); commit("inc16_wrap");
        op(1'b1, 1'b1, 3'd6, 16'h0000, 1'b0, 1'b0);
        op(1'b0, 1'b1, 3'd6, 16'h0000, 1'b0, 1'b0);
        post(0, 64'h00, 1'b0); post(1, 64'h5A, 1'b0); post(2, 64'h1234, 1'b0);
        commit("midrun_reset");
        op(1'b1, 1'b1, 3'd6, 16'h0000, 1'b0, 1'b0);
        post(0, 64'h01, 1'b0); post(1, 64'h5B, 1'b0); post(2, 64'h1235, 1'b0);
        commit("resume");

        // Randomised traffic against the model.
        for (int k = 0; k < 600; k++) begin
            op(($urandom_range(15) != 0) ? 1'b1 : 1'b0,
               ($urandom_range(3) != 0) ? 1'b1 : 1'b0,
               3'($urandom_range(7)),
               16'($urandom),
               1'($urandom_range(1)),
               1'($urandom_range(1)));
        end

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/universal_register.md
Name: universal_register

Overview:
Parametrised successor to the team's fixed 8-bit clearable register. It keeps the same data-in, data-out and clear structure and adds width parametrisation, a clock enable, and eight operating modes: hold, load, shifts, rotates, increment and decrement. It also registers a carry/shift-out flag and provides a zero flag. It is used as a general datapath register (accumulator, shift/serialiser stage, counter) in the team's small-CPU and serial designs.

Parameters:
WIDTH, 8, data width in bits; legal range 2..64.
RESET_VAL, 0, value loaded into Q on reset; WIDTH bits wide.

Ports:
clk  input  1  system clock; all state updates on rising edge.
clr  input  1  reset, synchronous, active-low; sampled on rising edge of clk.
en  input  1  clock enable; 0 = hold all state regardless of mode.
mode  input  3  operation select (encoding below).
D  input  WIDTH  parallel load data.
sin_l  input  1  serial bit entering at MSB on shift-right.
sin_r  input  1  serial bit entering at LSB on shift-left.
Q  output  WIDTH  register contents.
co  output  1  registered carry / borrow / shifted-out bit.
zero  output  1  combinational, 1 when Q == 0.

Behaviour:
- Priority at each rising clk edge:
  - clr==0: Q <= RESET_VAL, co <= 0. This applies regardless of en and mode.
  - else en==0: Q and co hold.
  - else apply mode.
- Reset is synchronous only. A clr low pulse between edges has no effect; an asynchronous clear is not implemented.
- Mode encoding, with the result at the next edge:
  - 000 HOLD: Q, co unchanged.
  - 001 LOAD: Q <= D; co <= 0.
  - 010 SHL: Q <= {Q[WIDTH-2:0], sin_r}; co <= Q[WIDTH-1].
  - 011 SHR: Q <= {sin_l, Q[WIDTH-1:1]}; co <= Q[0].
  - 100 ROL: Q <= {Q[WIDTH-2:0], Q[WIDTH-1]}; co <= Q[WIDTH-1].
  - 101 ROR: Q <= {Q[0], Q[WIDTH-1:1]}; co <= Q[0].
  - 110 INC: {co, Q} <= Q + 1, computed in WIDTH+1 bits. co=1 only on wrap from all-ones to 0.
  - 111 DEC: Q <= Q - 1 modulo 2^WIDTH. co <= 1 only on wrap from 0 to all-ones (borrow).
- Arithmetic is unsigned and modulo 2^WIDTH; no saturation.
- Latency: one cycle from an edge where en==1 to a new Q/co. zero follows Q combinationally in the same cycle.
- Reset values: Q = RESET_VAL; co = 0; zero = (RESET_VAL == 0).
- No X propagation from unused inputs: sin_l, sin_r and D are ignored outside their modes.
- Mode or en may change every cycle. Back-to-back operations chain on the registered Q with no bubbles.
- Reset mid-sequence (e.g. during a counting run) discards the in-flight operation. The first non-reset edge after clr returns high operates on RESET_VAL.

Decomposition:
- Shared package: mode encoding constants (MODE_HOLD … MODE_DEC), 3-bit mode width constant.
- One natural sub-module: universal_register_next. It is purely combinational, maps (Q, mode, D, sin_l, sin_r) to (q_next, co_next) and is parametrised by WIDTH. The top level keeps only the clr/en priority and the Q/co flops.
- zero is a single reduction in the top level.

Test Plan (WIDTH=8 unless noted):
1. Reset and priority: clr=0, en=1, mode=LOAD, D=8'hFF, one edge -> Q=8'h00, co=0, zero=1. Then clr=0 with en=0 -> still Q=00. With RESET_VAL=8'h5A -> Q=5A after reset.
2. Load and shifts:
   - LOAD 8'hFF; SHL with sin_r=0 -> Q=FE, co=1.
   - LOAD 8'hAA; SHR with sin_l=1 -> Q=D5, co=0.
   - Eight consecutive SHL with sin_r=1 from 00 -> Q=FF.
3. Rotates: LOAD 8'h81; ROL -> Q=03, co=1. LOAD 8'h81; ROR -> Q=C0, co=1. Eight ROL from 81 -> Q=81.
4. Count wrap:
   - LOAD 8'hFE; INC, INC -> Q=FF co=0, then Q=00 co=1 zero=1.
   - DEC from 00 -> Q=FF co=1; next DEC -> Q=FE co=0.
5. Enable/hold: LOAD 8'h3C; then en=0 with mode=LOAD, D=8'h55 for 3 cycles -> Q=3C, co unchanged. HOLD with en=1 -> same.
6. Parametric and mid-run reset: WIDTH=16, INC from 16'hFFFF -> 16'h0000, co=1. Pull clr low during an INC run -> Q=RESET_VAL on that edge, co=0, and counting resumes from RESET_VAL.
